// File: rtl/pic24_pkg.sv
// Shared types for the PIC24 instruction-fetch sequencer.
package pic24_pkg;

  localparam int unsigned PC_W    = 23;
  localparam int unsigned INSTR_W = 24;
  localparam int unsigned RPT_W   = 14;

  typedef logic [PC_W-1:0]    pc_t;
  typedef logic [INSTR_W-1:0] instr_t;

  typedef enum logic [1:0] {
    S_BOOT,
    S_REQ,
    S_WAIT,
    S_ISSUE
  } seq_state_e;

endpackage

// File: rtl/pic24_fetch_sequencer.sv
// PIC24 instruction-fetch sequencer: owns the PC, issues one program-memory read at a time,
// holds the returned word in the IR and offers it to execute over valid/ready. Handles branch
// redirects (dropping a stale in-flight read), REPEAT re-issue and debug halt.
module pic24_fetch_sequencer
  import pic24_pkg::*;
#(
  parameter int unsigned     PC_W         = 23,
  parameter int unsigned     INSTR_W      = 24,
  parameter int unsigned     RPT_W        = 14,
  parameter logic [PC_W-1:0] RESET_VECTOR = '0
) (
  input  logic               i_clk_50M,
  input  logic               i_rstn,
  output logic               o_pm_rd,
  output logic [PC_W-1:0]    o_pm_addr,
  input  logic               i_pm_valid,
  input  logic [INSTR_W-1:0] i_pm_rdata,
  output logic [INSTR_W-1:0] o_ir,
  output logic [PC_W-1:0]    o_ir_pc,
  output logic               o_ir_valid,
  input  logic               i_ex_ready,
  input  logic               i_br_taken,
  input  logic [PC_W-1:0]    i_br_target,
  input  logic               i_rpt_load,
  input  logic [RPT_W-1:0]   i_rpt_count,
  input  logic               i_halt,
  output logic               o_halted,
  output logic               o_rpt_active
);

  localparam logic [PC_W-1:0]  PcStep  = PC_W'(2);
  localparam logic [PC_W-1:0]  PcMask  = ~PC_W'(1);
  localparam logic [RPT_W-1:0] RptOne  = RPT_W'(1);

  seq_state_e          state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [PC_W-1:0]     ir_pc_q, ir_pc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic [RPT_W-1:0]    rpt_cnt_q, rpt_cnt_d;
  logic                drop_q, drop_d;

  logic [PC_W-1:0]     br_pc;
  logic                accept;
  logic                rpt_zero;

  assign br_pc    = i_br_target & PcMask;
  assign accept   = (state_q == S_ISSUE) && i_ex_ready;
  assign rpt_zero = (rpt_cnt_q == '0);

  // State register.
  always_ff @(posedge i_clk_50M or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= S_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a branch always returns to S_REQ except while a stale read is still due.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_BOOT:  state_d = S_REQ;
      S_REQ: begin
        if (!i_halt && !i_br_taken) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_pm_valid) state_d = (drop_q || i_br_taken) ? S_REQ : S_ISSUE;
      end
      S_ISSUE: begin
        if (i_br_taken) begin
          state_d = S_REQ;
        end else if (accept && rpt_zero) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  // Datapath registers: PC, IR, IR address, repeat counter and drop flag.
  always_ff @(posedge i_clk_50M or negedge i_rstn) begin
    if (!i_rstn) begin
      pc_q      <= RESET_VECTOR;
      ir_q      <= '0;
      ir_pc_q   <= '0;
      rpt_cnt_q <= '0;
      drop_q    <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      ir_pc_q   <= ir_pc_d;
      rpt_cnt_q <= rpt_cnt_d;
      drop_q    <= drop_d;
    end
  end

  // Datapath next-state; branch has priority over capture, re-issue and REPEAT load.
  always_comb begin
    pc_d      = pc_q;
    ir_d      = ir_q;
    ir_pc_d   = ir_pc_q;
    rpt_cnt_d = rpt_cnt_q;
    drop_d    = drop_q;
    if (i_br_taken) begin
      pc_d      = br_pc;
      rpt_cnt_d = '0;
      // A read still in flight must be swallowed when it eventually returns.
      if (state_q == S_WAIT) drop_d = !i_pm_valid;
    end else begin
      unique case (state_q)
        S_WAIT: begin
          if (i_pm_valid) begin
            if (drop_q) begin
              drop_d = 1'b0;
            end else begin
              ir_d    = i_pm_rdata;
              ir_pc_d = pc_q;
              pc_d    = pc_q + PcStep;
            end
          end
        end
        S_ISSUE: begin
          if (accept) begin
            if (!rpt_zero) begin
              rpt_cnt_d = rpt_cnt_q - RptOne;
            end else if (i_rpt_load) begin
              // Count applies to the instruction fetched next.
              rpt_cnt_d = i_rpt_count;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: read strobe only from S_REQ, so a second read can never overlap the first.
  always_comb begin
    o_pm_rd      = (state_q == S_REQ) && !i_halt && !i_br_taken;
    o_pm_addr    = pc_q;
    o_halted     = (state_q == S_REQ) && i_halt;
    o_ir_valid   = (state_q == S_ISSUE);
    o_ir         = ir_q;
    o_ir_pc      = ir_pc_q;
    o_rpt_active = !rpt_zero;
  end

endmodule
